// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared states and limits for the UART transmit arbiter
package uart_arb_pkg;
  localparam int UART_ARB_MAX_REQ = 8;
  typedef enum logic [2:0] {IDLE, HDR, FETCH, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_rr_pick: combinational round-robin picker, search starts at ptr and wraps at N_REQ
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    idx,
  output logic             any
);
  logic [IW:0] j;
  always_comb begin
    j = '0;
    idx = '0;
    any = 1'b0;
    // walk from the farthest candidate back so the closest one to ptr wins
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (IW+1)'(k);
      if (j >= (IW+1)'(N_REQ)) j = j - (IW+1)'(N_REQ);
      if (req[j[IW-1:0]]) begin
        idx = j[IW-1:0];
        any = 1'b1;
      end
    end
  end
  assign pick = any ? (N_REQ'(1) << idx) : '0;
  if (N_REQ < 2 || N_REQ > UART_ARB_MAX_REQ) begin : g_bad
    $error("uart_rr_pick: N_REQ out of range");
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one uart_tx between N_REQ byte sources
// Optional header byte per packet when UART_ARB_HEADER_EN is defined.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter logic [7:0] HDR_BASE = 8'h30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [N_REQ-1:0]     grant,
  output logic                 active
);
  localparam int IW = $clog2(N_REQ);
  state_t state, nxt;
  logic [IW-1:0] rr_ptr, g, idx;
  logic [N_REQ-1:0] pick;
  logic any, last_q, vg, lg;
  logic [7:0] sel;
  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .pick(pick),
    .idx(idx),
    .any(any)
  );
  if ($bits(HDR_BASE) != 8) begin : g_bad
    $error("uart_tx_arbiter: HDR_BASE must be a byte");
  end
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++) if (grant[i]) sel = req_data[8*i +: 8];
  end
  assign vg = |(req_valid & grant);
  assign lg = |(req_last & grant);
  always_comb begin
    nxt = state;
    case (state)
`ifdef UART_ARB_HEADER_EN
      IDLE:      nxt = any ? HDR : IDLE;
      HDR:       nxt = ISSUE;
`else
      IDLE:      nxt = any ? FETCH : IDLE;
`endif
      FETCH:     nxt = vg ? ISSUE : FETCH;
      ISSUE:     nxt = tx_busy ? ISSUE : WAIT_ACK;
      WAIT_ACK:  nxt = tx_busy ? WAIT_DONE : WAIT_ACK;
      WAIT_DONE: nxt = tx_busy ? WAIT_DONE : (last_q ? IDLE : FETCH);
      default:   nxt = IDLE;
    endcase
  end
  assign req_ready = (state == FETCH) ? (grant & req_valid) : '0;
  assign tx_start = (state == ISSUE) && !tx_busy;
  assign active = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      g <= '0;
      rr_ptr <= '0;
      last_q <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      state <= nxt;
      if (state == IDLE && any) begin
        grant <= pick;
        g <= idx;
      end
`ifdef UART_ARB_HEADER_EN
      if (state == HDR) begin
        tx_data <= HDR_BASE + 8'(g);
        last_q <= 1'b0;
      end
`endif
      if (state == FETCH && vg) begin
        tx_data <= sel;
        last_q <= lg;
      end
      if (state == WAIT_DONE && !tx_busy && last_q) begin
        rr_ptr <= (g == IW'(N_REQ - 1)) ? '0 : g + IW'(1);
        grant <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vector table plus packet sequences against a 20-cycle uart_tx model
module tb_uart_tx_arbiter;
  logic clk = 1'b0, rst = 1'b1, tx_busy, tb_busy = 1'b0, use_model = 1'b0;
  logic [3:0] req_valid = '0, req_last = '0, req_ready, grant;
  logic [31:0] req_data = '0;
  logic tx_start, active;
  logic [7:0] tx_data;
  int checks = 0, errors = 0, cnt = 0;
  logic [7:0] ld[$];
  logic [3:0] lg[$];

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .active(active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (tx_start) cnt <= 20; else if (cnt != 0) cnt <= cnt - 1;
  assign tx_busy = use_model ? (cnt != 0) : tb_busy;
  always @(negedge clk) if (tx_start) begin ld.push_back(tx_data); lg.push_back(grant); end

  typedef struct {
    logic [3:0] v, l; logic [7:0] d0, d1; logic b;
    logic [3:0] eg, er; logic es; logic [7:0] ed; logic ea;
  } vec_t;
  vec_t tv[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", nm);
  endtask

  task automatic send(input int r, input logic [7:0] d, input logic lst);
    bit ok = 0;
    req_valid[r] = 1'b1;
    req_data[8*r +: 8] = d;
    req_last[r] = lst;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin ok = 1; break; end
    end
    if (!ok) timeout($sformatf("ready%0d", r));
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    req_last[r] = 1'b0;
  endtask

  task automatic two(input int r);
    send(r, 8'(32 + 16*r), 1'b1);
    send(r, 8'(33 + 16*r), 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!active && !tx_busy) return;
    end
    timeout("idle");
  endtask

  task automatic do_reset();
    for (int i = 0; i < 100 && tx_busy; i++) @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    ld.delete();
    lg.delete();
  endtask

  task automatic chk_log(input int i, input logic [7:0] d, input logic [3:0] g);
    chk($sformatf("log%0d data", i), (i < ld.size()) ? ld[i] : 8'hxx, d);
    chk($sformatf("log%0d grant", i), (i < lg.size()) ? lg[i] : 4'hx, g);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int gbad, rbad, bad, n0;
    tv[0]  = '{4'b0001, 4'b0001, 8'hA1, 8'h00, 0, 4'b0000, 4'b0000, 0, 8'h00, 0};
    tv[1]  = '{4'b0001, 4'b0001, 8'hA1, 8'h00, 0, 4'b0001, 4'b0001, 0, 8'h00, 1};
    tv[2]  = '{4'b0000, 4'b0000, 8'h00, 8'h00, 0, 4'b0001, 4'b0000, 1, 8'hA1, 1};
    tv[3]  = '{4'b0000, 4'b0000, 8'h00, 8'h00, 1, 4'b0001, 4'b0000, 0, 8'hA1, 1};
    tv[4]  = '{4'b0000, 4'b0000, 8'h00, 8'h00, 1, 4'b0001, 4'b0000, 0, 8'hA1, 1};
    tv[5]  = '{4'b0011, 4'b0011, 8'hB0, 8'hB1, 0, 4'b0001, 4'b0000, 0, 8'hA1, 1};
    tv[6]  = '{4'b0011, 4'b0011, 8'hB0, 8'hB1, 0, 4'b0000, 4'b0000, 0, 8'hA1, 0};
    tv[7]  = '{4'b0011, 4'b0011, 8'hB0, 8'hB1, 0, 4'b0010, 4'b0010, 0, 8'hA1, 1};
    tv[8]  = '{4'b0001, 4'b0001, 8'hB0, 8'h00, 1, 4'b0010, 4'b0000, 0, 8'hB1, 1};
    tv[9]  = '{4'b0001, 4'b0001, 8'hB0, 8'h00, 0, 4'b0010, 4'b0000, 1, 8'hB1, 1};
    tv[10] = '{4'b0001, 4'b0001, 8'hB0, 8'h00, 0, 4'b0010, 4'b0000, 0, 8'hB1, 1};
    tv[11] = '{4'b0001, 4'b0001, 8'hB0, 8'h00, 1, 4'b0010, 4'b0000, 0, 8'hB1, 1};
    tv[12] = '{4'b0001, 4'b0001, 8'hB0, 8'h00, 0, 4'b0010, 4'b0000, 0, 8'hB1, 1};
    tv[13] = '{4'b0001, 4'b0001, 8'hB0, 8'h00, 0, 4'b0000, 4'b0000, 0, 8'hB1, 0};
    tv[14] = '{4'b0001, 4'b0001, 8'hB0, 8'h00, 0, 4'b0001, 4'b0001, 0, 8'hB1, 1};
    tv[15] = '{4'b0000, 4'b0000, 8'h00, 8'h00, 0, 4'b0001, 4'b0000, 1, 8'hB0, 1};
    tv[16] = '{4'b0000, 4'b0000, 8'h00, 8'h00, 1, 4'b0001, 4'b0000, 0, 8'hB0, 1};
    tv[17] = '{4'b0000, 4'b0000, 8'h00, 8'h00, 0, 4'b0001, 4'b0000, 0, 8'hB0, 1};
    tv[18] = '{4'b0000, 4'b0000, 8'h00, 8'h00, 0, 4'b0000, 4'b0000, 0, 8'hB0, 0};
    repeat (2) @(negedge clk);
    chk("rst grant", grant, 4'b0000);
    chk("rst ready", req_ready, 4'b0000);
    chk("rst start", tx_start, 1'b0);
    chk("rst data", tx_data, 8'h00);
    chk("rst active", active, 1'b0);
    rst = 1'b0;
`ifdef UART_ARB_HEADER_EN
    use_model = 1'b1;
    do_reset();
    send(3, 8'h55, 1'b1);
    wait_idle();
    chk("hdr count", ld.size(), 2);
    chk_log(0, 8'h33, 4'b1000);
    chk_log(1, 8'h55, 4'b1000);
`else
    for (int i = 0; i < 19; i++) begin
      @(posedge clk);
      #1;
      req_valid = tv[i].v;
      req_last = tv[i].l;
      req_data[7:0] = tv[i].d0;
      req_data[15:8] = tv[i].d1;
      tb_busy = tv[i].b;
      #1;
      chk($sformatf("v%0d grant", i), grant, tv[i].eg);
      chk($sformatf("v%0d ready", i), req_ready, tv[i].er);
      chk($sformatf("v%0d start", i), tx_start, tv[i].es);
      chk($sformatf("v%0d data", i), tx_data, tv[i].ed);
      chk($sformatf("v%0d active", i), active, tv[i].ea);
    end
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    use_model = 1'b1;

    do_reset();
    send(0, 8'h41, 1'b0);
    send(0, 8'h42, 1'b0);
    send(0, 8'h43, 1'b1);
    wait_idle();
    chk("seqA count", ld.size(), 3);
    chk_log(0, 8'h41, 4'b0001);
    chk_log(1, 8'h42, 4'b0001);
    chk_log(2, 8'h43, 4'b0001);
    chk("seqA grant end", grant, 4'b0000);

    do_reset();
    fork send(0, 8'h10, 1'b1); send(1, 8'h11, 1'b1); join
    wait_idle();
    fork send(0, 8'h12, 1'b1); send(2, 8'h13, 1'b1); join
    wait_idle();
    chk_log(0, 8'h10, 4'b0001);
    chk_log(1, 8'h11, 4'b0010);
    chk_log(2, 8'h13, 4'b0100);
    chk_log(3, 8'h12, 4'b0001);

    do_reset();
    fork two(0); two(1); two(2); two(3); join
    wait_idle();
    chk("seqC count", ld.size(), 8);
    for (int i = 0; i < 8; i++) chk_log(i, 8'(32 + 16*(i%4) + i/4), 4'(1 << (i%4)));

    do_reset();
    send(2, 8'h61, 1'b0);
    req_valid[1] = 1'b1;
    req_data[15:8] = 8'h71;
    req_last[1] = 1'b1;
    gbad = 0;
    rbad = 0;
    repeat (50) begin
      @(negedge clk);
      if (grant !== 4'b0100) gbad++;
      if (req_ready[1]) rbad++;
    end
    chk("gap grant", gbad, 0);
    chk("gap ready1", rbad, 0);
    chk("gap starts", ld.size(), 1);
    send(2, 8'h62, 1'b1);
    send(1, 8'h71, 1'b1);
    wait_idle();
    chk_log(0, 8'h61, 4'b0100);
    chk_log(1, 8'h62, 4'b0100);
    chk_log(2, 8'h71, 4'b0010);

    do_reset();
    send(0, 8'h81, 1'b1);
    for (int i = 0; i < 100 && ld.size() == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("pre-rst busy", tx_busy, 1'b1);
    chk("pre-rst active", active, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid-rst grant", grant, 4'b0000);
    chk("mid-rst active", active, 1'b0);
    chk("mid-rst data", tx_data, 8'h00);
    chk("mid-rst start", tx_start, 1'b0);
    chk("mid-rst ready", req_ready, 4'b0000);
    @(negedge clk) rst = 1'b0;
    n0 = ld.size();
    bad = 0;
    fork
      send(1, 8'h91, 1'b1);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (!tx_busy) break;
        if (tx_start) bad++;
      end
    join
    chk("post-rst start while busy", bad, 0);
    wait_idle();
    chk("post-rst count", ld.size(), n0 + 1);
    chk_log(n0, 8'h91, 4'b0010);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
